pixel_coord_gen: RTL and testbench
==================================

PIXEL_COORD_GEN -- requirements
Module: pixel_coord_gen

Interface
REQ-001 SHALL have parameter COORD_W, default 13, width of row/col/count outputs.
REQ-002 SHALL have parameter MAX_COLS, default 1280, pixels per line above which columns saturate.
REQ-003 SHALL have parameter MAX_ROWS, default 960, lines per frame above which rows saturate.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port fval  input  1  camera frame-valid level.
REQ-007 SHALL have port lval  input  1  camera line-valid level.
REQ-008 SHALL have port dval  input  1  pixel-valid strobe; meaningful only while fval and lval are high.
REQ-009 SHALL have port pix_in  input  1  classified/denoised pixel mask bit.
REQ-010 SHALL have port out_img  output  1  registered mask bit, forced 0 when no valid pixel.
REQ-011 SHALL have port row  output  COORD_W  line index of the current out_img pixel.
REQ-012 SHALL have port col  output  COORD_W  column index of the current out_img pixel.
REQ-013 SHALL have port V_sync  output  1  one-cycle end-of-frame pulse.
REQ-014 SHALL have port frame_rows  output  COORD_W  number of lines in the last completed frame.
REQ-015 SHALL have port line_cols  output  COORD_W  pixel count of the last completed line.
REQ-016 SHALL have port ovf  output  1  sticky flag: a saturation limit was hit.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_LINE, IN_LINE and FRAME_END.
REQ-018 IDLE SHALL go to WAIT_LINE on fval rising edge (0 then 1) with lval=0; fval high at reset exit or with lval=1 SHALL wait for the next clean rising edge.
REQ-019 WAIT_LINE SHALL go to IN_LINE on lval rising edge, with col cleared to 0.
REQ-020 IN_LINE SHALL, per cycle with dval=1: drive out_img=pix_in, row/col equal to the current counters, then increment col.
REQ-021 In IN_LINE, on lval falling edge: latch col count into line_cols, increment row, return to WAIT_LINE.
REQ-022 On fval falling edge in WAIT_LINE or IN_LINE: go to FRAME_END; a line cut short by the fval fall SHALL count as a line.
REQ-023 FRAME_END SHALL last one cycle, assert V_sync, latch row count into frame_rows, clear row and col, then return to IDLE.
REQ-024 Latency: inputs sampled at edge N SHALL appear on out_img/row/col at edge N+1; V_sync SHALL occur 2 cycles after the cycle fval was sampled low.
REQ-025 out_img SHALL be 0 whenever dval=0, lval=0, or the state is not IN_LINE; row/col SHALL hold their last values there.
REQ-026 Columns at or beyond MAX_COLS: col SHALL hold at MAX_COLS-1, out_img SHALL be 0, and ovf SHALL set.
REQ-027 Rows at or beyond MAX_ROWS: row SHALL hold at MAX_ROWS-1, out_img SHALL be 0, and ovf SHALL set.
REQ-028 ovf SHALL clear only on reset.
REQ-029 If lval and fval fall in the same cycle, the line latch and the FRAME_END transition SHALL both occur, and frame_rows SHALL include that line.
REQ-030 V_sync SHALL never be asserted in the same cycle as out_img=1.

Reset
REQ-031 While reset=0, all outputs SHALL be 0 and the state SHALL be IDLE, regardless of clk.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no V_sync issued; operation SHALL resume at the next clean fval rise.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, COORD_W, and the MAX_COLS/MAX_ROWS defaults.
REQ-034 A sub-module edge_det (1-bit registered rise/fall detector) SHALL be instantiated for fval and for lval.

Verification
REQ-035 Bench SHALL cover: 4x3 frame, dval always 1, pix_in=1 at (1,2) -> out_img=1 exactly once with row=1, col=2; V_sync pulse; frame_rows=3; line_cols=4.
REQ-036 Bench SHALL cover: dval toggling 1,0,1,0 over 4 cycles -> col 0 then 1 only; out_img=0 in dval=0 cycles.
REQ-037 Bench SHALL cover: MAX_COLS=4 with 6-pixel line -> col holds 3, out_img=0 for pixels 4 and 5, ovf=1, line_cols=4.
REQ-038 Bench SHALL cover: fval falls mid-line after 2 pixels of line 1 -> V_sync issued, frame_rows=2.
REQ-039 Bench SHALL cover: reset pulse mid-line 1 -> outputs 0 immediately, no V_sync; the next full frame measures correctly.
REQ-040 Bench SHALL cover: fval already high at reset release -> no pixels emitted until the following fval rise.

Source files
------------

// File: rtl/pixel_coord_gen_pkg.sv
// Shared definitions for the pixel coordinate generator: FSM encoding and
// default geometry/width parameters.
package pixel_coord_gen_pkg;

    localparam int COORD_W_DEF  = 13;
    localparam int MAX_COLS_DEF = 1280;
    localparam int MAX_ROWS_DEF = 960;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        IN_LINE   = 2'd2,
        FRAME_END = 2'd3
    } state_t;

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector on a registered copy of a 1-bit level.
// Latency: combinational edge flags against the previous-cycle sample.
// Backpressure: none.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // History resets high so a level already asserted at reset exit is not a rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/pixel_coord_gen.sv
// Tags camera mask pixels with row/col coordinates and measures frame/line size.
// Latency: pixel to out_img/row/col one cycle; fval fall to V_sync two cycles.
// Backpressure: none; the camera stream is accepted every cycle.
module pixel_coord_gen
    import pixel_coord_gen_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int MAX_ROWS = MAX_ROWS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fval,
    input  logic               lval,
    input  logic               dval,
    input  logic               pix_in,
    output logic               out_img,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               V_sync,
    output logic [COORD_W-1:0] frame_rows,
    output logic [COORD_W-1:0] line_cols,
    output logic               ovf
);

    localparam logic [COORD_W-1:0] COL_LIM = COORD_W'(MAX_COLS);
    localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(MAX_ROWS);
    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(MAX_COLS - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(MAX_ROWS - 1);

    state_t             state;
    logic [COORD_W-1:0] cnt_col;
    logic [COORD_W-1:0] cnt_row;
    logic [COORD_W-1:0] cur_col;
    logic [COORD_W-1:0] row_next;
    logic               fval_rise, fval_fall, lval_rise, lval_fall;
    logic               pix_take, col_sat, row_sat;

    edge_det u_fval_edge (.clk(clk), .reset(reset), .d(fval), .rise(fval_rise), .fall(fval_fall));
    edge_det u_lval_edge (.clk(clk), .reset(reset), .d(lval), .rise(lval_rise), .fall(lval_fall));

    // The pixel on the lval rise cycle is the first pixel of the line (col 0).
    always_comb begin
        cur_col  = (state == IN_LINE) ? cnt_col : '0;
        col_sat  = (cur_col >= COL_LIM);
        row_sat  = (cnt_row >= ROW_LIM);
        row_next = row_sat ? ROW_LIM : cnt_row + 1'b1;
        pix_take = fval && lval && dval &&
                   ((state == IN_LINE) || ((state == WAIT_LINE) && lval_rise));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt_col    <= '0;
            cnt_row    <= '0;
            out_img    <= 1'b0;
            row        <= '0;
            col        <= '0;
            V_sync     <= 1'b0;
            frame_rows <= '0;
            line_cols  <= '0;
            ovf        <= 1'b0;
        end else begin
            out_img <= 1'b0;
            V_sync  <= 1'b0;

            case (state)
                IDLE: begin
                    if (fval_rise && !lval) state <= WAIT_LINE;
                end
                WAIT_LINE: begin
                    if (fval_fall) begin
                        state <= FRAME_END;
                    end else if (lval_rise) begin
                        state   <= IN_LINE;
                        cnt_col <= '0;
                    end
                end
                IN_LINE: begin
                    // A line cut short by the frame ending still counts as a line.
                    if (fval_fall || lval_fall) begin
                        line_cols <= cnt_col;
                        cnt_row   <= row_next;
                        cnt_col   <= '0;
                        state     <= fval_fall ? FRAME_END : WAIT_LINE;
                    end
                end
                FRAME_END: begin
                    V_sync     <= 1'b1;
                    frame_rows <= cnt_row;
                    cnt_row    <= '0;
                    cnt_col    <= '0;
                    row        <= '0;
                    col        <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (pix_take) begin
                out_img <= pix_in && !col_sat && !row_sat;
                row     <= row_sat ? ROW_MAX : cnt_row;
                col     <= col_sat ? COL_MAX : cur_col;
                cnt_col <= col_sat ? COL_LIM : cur_col + 1'b1;
                if (col_sat || row_sat) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed-frame bench: frame-level tasks derive expected outputs from frame
// position, a negedge process compares every output every cycle.
module tb_pixel_coord_gen;

    localparam int CW = 13;
    localparam int MC = 4;
    localparam int MR = 4;

    logic          clk;
    logic          reset;
    logic          fval, lval, dval, pix_in;
    logic          out_img, V_sync, ovf;
    logic [CW-1:0] row, col, frame_rows, line_cols;

    pixel_coord_gen #(.COORD_W(CW), .MAX_COLS(MC), .MAX_ROWS(MR)) dut (
        .clk(clk), .reset(reset), .fval(fval), .lval(lval), .dval(dval),
        .pix_in(pix_in), .out_img(out_img), .row(row), .col(col),
        .V_sync(V_sync), .frame_rows(frame_rows), .line_cols(line_cols), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_hot = 0;
    int n_vs  = 0;
    int hot_row = 0;
    int hot_col = 0;
    bit chk_on = 0;

    // Expected outputs after the most recent edge (e_*) and after the next one (nx_*).
    int e_img = 0, e_row = 0, e_col = 0, e_vs = 0, e_fr = 0, e_lc = 0, e_ovf = 0;
    int nx_img = 0, nx_row = 0, nx_col = 0, nx_vs = 0, nx_fr = 0, nx_lc = 0, nx_ovf = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_img",    int'(out_img),    e_img);
            chk("row",        int'(row),        e_row);
            chk("col",        int'(col),        e_col);
            chk("V_sync",     int'(V_sync),     e_vs);
            chk("frame_rows", int'(frame_rows), e_fr);
            chk("line_cols",  int'(line_cols),  e_lc);
            chk("ovf",        int'(ovf),        e_ovf);
            chk("vsync_with_pixel", int'(V_sync && out_img), 0);
            if (out_img) begin
                n_hot++;
                hot_row = int'(row);
                hot_col = int'(col);
            end
        end
        if (V_sync) n_vs++;
    end

    task automatic model_clear();
        e_img = 0; e_row = 0; e_col = 0; e_vs = 0; e_fr = 0; e_lc = 0; e_ovf = 0;
        nx_img = 0; nx_row = 0; nx_col = 0; nx_vs = 0; nx_fr = 0; nx_lc = 0; nx_ovf = 0;
    endtask

    task automatic step(input logic f, input logic l, input logic d, input logic p);
        fval = f; lval = l; dval = d; pix_in = p;
        @(posedge clk);
        e_img = nx_img; e_row = nx_row; e_col = nx_col; e_vs = nx_vs;
        e_fr = nx_fr; e_lc = nx_lc; e_ovf = nx_ovf;
        nx_img = 0;
        nx_vs  = 0;
        #1;
    endtask

    task automatic pixel(input int r, input int k, input logic p);
        nx_img = (p && k < MC && r < MR) ? 1 : 0;
        nx_row = (r < MR) ? r : MR - 1;
        nx_col = (k < MC) ? k : MC - 1;
        if (k >= MC || r >= MR) nx_ovf = 1;
        step(1, 1, 1, p);
    endtask

    task automatic frame_open();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    // ncyc lval-high cycles; dmask selects dval cycles, pmask the mask bit.
    task automatic line(input int r, input logic [7:0] dmask, input logic [7:0] pmask,
                        input int ncyc, input bit close);
        int k = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (dmask[i]) begin
                pixel(r, k, pmask[i]);
                k++;
            end else begin
                step(1, 1, 0, pmask[i]);
            end
        end
        nx_lc = (k < MC) ? k : MC;
        if (close) begin
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
        end
    endtask

    task automatic frame_close(input int nrows);
        step(0, 0, 0, 0);
        nx_vs  = 1;
        nx_fr  = (nrows < MR) ? nrows : MR;
        nx_row = 0;
        nx_col = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic do_reset(input logic f_hold);
        chk_on = 0;
        #2;
        reset = 1'b0;
        fval = f_hold; lval = 1'b0; dval = 1'b0; pix_in = 1'b0;
        #1;
        chk("rst_out_img",    int'(out_img),    0);
        chk("rst_row",        int'(row),        0);
        chk("rst_col",        int'(col),        0);
        chk("rst_V_sync",     int'(V_sync),     0);
        chk("rst_frame_rows", int'(frame_rows), 0);
        chk("rst_line_cols",  int'(line_cols),  0);
        chk("rst_ovf",        int'(ovf),        0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        chk_on = 1;
    endtask

    initial begin
        reset = 1'b1; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_in = 1'b0;
        model_clear();
        #2 reset = 1'b0;
        #1;
        chk("init_out_img", int'(out_img), 0);
        chk("init_row",     int'(row),     0);
        chk("init_col",     int'(col),     0);
        chk("init_V_sync",  int'(V_sync),  0);
        chk("init_ovf",     int'(ovf),     0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk_on = 1;

        // 4x3 frame, one hot pixel at (1,2)
        n_hot = 0; n_vs = 0;
        frame_open();
        line(0, 8'h0F, 8'h00, 4, 1);
        line(1, 8'h0F, 8'h04, 4, 1);
        line(2, 8'h0F, 8'h00, 4, 1);
        frame_close(3);
        chk("a_hot_cnt",    n_hot, 1);
        chk("a_hot_row",    hot_row, 1);
        chk("a_hot_col",    hot_col, 2);
        chk("a_vsync_cnt",  n_vs, 1);
        chk("a_frame_rows", int'(frame_rows), 3);
        chk("a_line_cols",  int'(line_cols), 4);

        // dval toggling 1,0,1,0 with pix_in held high
        n_hot = 0; n_vs = 0;
        frame_open();
        line(0, 8'h05, 8'h0F, 4, 1);
        frame_close(1);
        chk("b_hot_cnt",   n_hot, 2);
        chk("b_last_col",  hot_col, 1);
        chk("b_line_cols", int'(line_cols), 2);

        // column then row saturation
        n_vs = 0;
        frame_open();
        line(0, 8'h3F, 8'h3F, 6, 1);
        chk("c_line_cols", int'(line_cols), 4);
        chk("c_col_hold",  int'(col), 3);
        chk("c_ovf",       int'(ovf), 1);
        for (int r = 1; r < 5; r++) line(r, 8'h01, 8'h01, 1, 1);
        chk("c_row_hold",  int'(row), 3);
        frame_close(5);
        chk("c_frame_rows", int'(frame_rows), 4);
        chk("c_vsync_cnt",  n_vs, 1);

        // fval and lval fall together after two pixels of line 1
        n_vs = 0;
        frame_open();
        line(0, 8'h0F, 8'h00, 4, 1);
        line(1, 8'h03, 8'h03, 2, 0);
        frame_close(2);
        chk("d_frame_rows", int'(frame_rows), 2);
        chk("d_line_cols",  int'(line_cols), 2);
        chk("d_vsync_cnt",  n_vs, 1);

        // reset mid-line 1, then a clean frame
        frame_open();
        line(0, 8'h0F, 8'h00, 4, 1);
        pixel(1, 0, 1);
        pixel(1, 1, 1);
        n_vs = 0;
        do_reset(1'b0);
        frame_open();
        line(0, 8'h0F, 8'h00, 4, 1);
        line(1, 8'h0F, 8'h00, 4, 1);
        line(2, 8'h0F, 8'h00, 4, 1);
        frame_close(3);
        chk("e_frame_rows", int'(frame_rows), 3);
        chk("e_vsync_cnt",  n_vs, 1);
        chk("e_ovf",        int'(ovf), 0);

        // fval already high at reset release: that frame is ignored
        do_reset(1'b1);
        n_hot = 0; n_vs = 0;
        repeat (3) step(1, 1, 1, 1);
        step(1, 0, 0, 0);
        repeat (2) step(1, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0);
        chk("f_no_pixels", n_hot, 0);
        chk("f_no_vsync",  n_vs, 0);
        frame_open();
        line(0, 8'h03, 8'h00, 2, 1);
        line(1, 8'h03, 8'h02, 2, 1);
        frame_close(2);
        chk("f_frame_rows", int'(frame_rows), 2);
        chk("f_hot_cnt",    n_hot, 1);
        chk("f_hot_row",    hot_row, 1);
        chk("f_hot_col",    hot_col, 1);

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
